// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM port arbiter.
// Optional clear engine is selected with the VRAM_CLEAR_EN macro in vram_port_arbiter.
package vram_pkg;

  localparam int AW        = 15;
  localparam int DW        = 12;
  localparam int MEM_WORDS = 30000;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [AW-1:0] vaddr_t;

  typedef struct packed {
    vaddr_t addr;
    pixel_t data;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

  localparam vaddr_t LAST_ADDR = vaddr_t'(MEM_WORDS - 1);

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-request FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_px,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wr_req_t din,
  output wr_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  wr_req_t        store_r [DEPTH];
  logic [PW:0]    wr_ptr_r;
  logic [PW:0]    rd_ptr_r;
  logic           do_push_s;
  logic           do_pop_s;

  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                     (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign dout      = store_r[rd_ptr_r[PW-1:0]];

  // Read and write pointers.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clk_px) begin
    if (do_push_s) store_r[wr_ptr_r[PW-1:0]] <= din;
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display reads first, buffered writes second, clear fill last.
// Define VRAM_CLEAR_EN to compile in the full-buffer clear engine.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_px,
  input  logic          rst,
  input  logic          disp_re,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_req,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  wr_req_t push_req_s;
  wr_req_t head_s;
  logic    fifo_full_s;
  logic    fifo_empty_s;
  logic    push_s;
  logic    pop_s;
  logic    clear_we_s;
  vaddr_t  clr_ptr_s;
  pixel_t  clr_color_s;
  logic    we_s;

  assign disp_rdata = mem_rdata;
  assign push_req_s = '{addr: wr_addr, data: wr_data};
  assign push_s     = wr_valid & wr_ready;
  assign pop_s      = ~disp_re & ~fifo_empty_s;

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_px (clk_px),
    .rst    (rst),
    .push   (push_s),
    .pop    (pop_s),
    .din    (push_req_s),
    .dout   (head_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

`ifdef VRAM_CLEAR_EN
  arb_state_t state_r;
  arb_state_t state_nxt_s;
  vaddr_t     clr_ptr_r;
  vaddr_t     clr_ptr_nxt_s;
  pixel_t     clr_color_r;
  pixel_t     clr_color_nxt_s;

  // The FIFO is always empty in CLEAR because writers are held off from DRAIN onwards.
  assign clear_we_s  = (state_r == CLEAR) & ~disp_re & fifo_empty_s;
  assign clr_ptr_s   = clr_ptr_r;
  assign clr_color_s = clr_color_r;
  assign wr_ready    = ~fifo_full_s & (state_r == IDLE);
  assign clr_busy    = (state_r != IDLE);

  // Clear engine state, fill pointer and latched colour.
  always_ff @(posedge clk_px or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      clr_ptr_r   <= '0;
      clr_color_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      clr_ptr_r   <= clr_ptr_nxt_s;
      clr_color_r <= clr_color_nxt_s;
    end
  end

  // Clear engine next-state logic; clr_req outside IDLE is ignored.
  always_comb begin
    state_nxt_s     = state_r;
    clr_ptr_nxt_s   = clr_ptr_r;
    clr_color_nxt_s = clr_color_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          state_nxt_s     = DRAIN;
          clr_color_nxt_s = clr_color;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (fifo_empty_s) begin
          state_nxt_s   = CLEAR;
          clr_ptr_nxt_s = '0;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      CLEAR: begin
        if (clear_we_s) begin
          if (clr_ptr_r == LAST_ADDR) begin
            state_nxt_s   = IDLE;
            clr_ptr_nxt_s = '0;
          end else begin
            clr_ptr_nxt_s = clr_ptr_r + vaddr_t'(1);
          end
        end else begin
          clr_ptr_nxt_s = clr_ptr_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        clr_ptr_nxt_s = '0;
      end
    endcase
  end
`else
  logic unused_clr_s;

  assign unused_clr_s = ^{clr_req, clr_color};
  assign clear_we_s   = 1'b0;
  assign clr_ptr_s    = '0;
  assign clr_color_s  = '0;
  assign wr_ready     = ~fifo_full_s;
  assign clr_busy     = 1'b0;
`endif

  // Port priority: display read, then FIFO head, then clear fill.
  always_comb begin
    mem_addr  = disp_addr;
    we_s      = 1'b0;
    mem_wdata = '0;
    if (disp_re) begin
      mem_addr = disp_addr;
    end else if (!fifo_empty_s) begin
      mem_addr  = head_s.addr;
      we_s      = 1'b1;
      mem_wdata = head_s.data;
    end else if (clear_we_s) begin
      mem_addr  = clr_ptr_s;
      we_s      = 1'b1;
      mem_wdata = clr_color_s;
    end else begin
      mem_addr = disp_addr;
    end
  end

  assign mem_we = we_s & ~rst;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed self-checking bench for vram_port_arbiter with a behavioural VRAM
// and a log of every VRAM write; clear tests run when VRAM_CLEAR_EN is defined.
module tb_vram_port_arbiter;

  logic        clk_px = 1'b0;
  logic        rst;
  logic        disp_re;
  logic [14:0] disp_addr;
  logic [11:0] disp_rdata;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = 12'h000;

  int checks   = 0;
  int failures = 0;

  logic [11:0] vram [32768];
  logic [14:0] log_addr [$];
  logic [11:0] log_data [$];
  int          we_during_re = 0;

  always #10 clk_px = ~clk_px;

  vram_port_arbiter dut (
    .clk_px     (clk_px),
    .rst        (rst),
    .disp_re    (disp_re),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // VRAM model with one-cycle synchronous read, plus write log.
  always @(posedge clk_px) begin
    if (mem_we) begin
      vram[mem_addr] <= mem_wdata;
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      if (disp_re) we_during_re <= we_during_re + 1;
    end
    mem_rdata <= vram[mem_addr];
  end

  task automatic next_cycle();
    @(negedge clk_px);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_re = 1'b0; disp_addr = 15'h0ABC;
    wr_valid = 1'b0; wr_addr = 15'h0000; wr_data = 12'h000;
    clr_req = 1'b0; clr_color = 12'h000;
    next_cycle(); #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0h exp=0", mem_we); end
    checks++; if (mem_wdata !== 12'h000) begin failures++; $display("FAIL reset_wdata got=%h exp=000", mem_wdata); end
    checks++; if (mem_addr !== 15'h0ABC) begin failures++; $display("FAIL reset_addr got=%h exp=0abc", mem_addr); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", wr_ready); end
    checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", clr_busy); end
    next_cycle(); rst = 1'b0;
    // Queue three writes behind a display read, then reset before they retire.
    disp_re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 15'h0050 + 15'(i); wr_data = 12'h700 + 12'(i);
      next_cycle();
    end
    wr_valid = 1'b0; disp_re = 1'b0; #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL midtraffic_we got=%0h exp=1", mem_we); end
    rst = 1'b1; #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_gate_we got=%0h exp=0", mem_we); end
    next_cycle(); rst = 1'b0; clear_log();
    #1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%0h exp=1", wr_ready); end
    checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy got=%0h exp=0", clr_busy); end
    repeat (5) next_cycle();
    checks++; if (log_addr.size() != 0) begin failures++; $display("FAIL post_rst_empty writes=%0d exp=0", log_addr.size()); end
  endtask

  task automatic test_display_priority();
    logic [14:0] ea [4];
    logic [11:0] ed [4];
    ea[0] = 15'h0010; ed[0] = 12'hF00;
    ea[1] = 15'h0011; ed[1] = 12'h0F0;
    ea[2] = 15'h0012; ed[2] = 12'h00F;
    ea[3] = 15'h0013; ed[3] = 12'hFFF;
    clear_log();
    disp_re = 1'b1; disp_addr = 15'h0100;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_addr  = (i < 4) ? ea[i] : 15'h0014;
      wr_data  = (i < 4) ? ed[i] : 12'h123;
      #1;
      checks++; if (wr_ready !== (i < 4)) begin failures++; $display("FAIL prio_ready[%0d] got=%0h exp=%0h", i, wr_ready, (i < 4)); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL prio_we_during_read[%0d] got=%0h exp=0", i, mem_we); end
      next_cycle();
    end
    wr_valid = 1'b0; disp_re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== ea[i] || mem_wdata !== ed[i]) begin
        failures++;
        $display("FAIL prio_drain[%0d] got we=%0h addr=%h data=%h exp we=1 addr=%h data=%h",
                 i, mem_we, mem_addr, mem_wdata, ea[i], ed[i]);
      end
      next_cycle();
    end
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL prio_after_drain_we got=%0h exp=0", mem_we); end
  endtask

  task automatic test_read_path();
    disp_re = 1'b0; wr_valid = 1'b1; wr_addr = 15'h1234; wr_data = 12'hABC; #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL lat_accept_we got=%0h exp=0", mem_we); end
    next_cycle(); wr_valid = 1'b0; #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 15'h1234) begin failures++; $display("FAIL lat_retire got we=%0h addr=%h exp we=1 addr=1234", mem_we, mem_addr); end
    next_cycle(); disp_re = 1'b1; disp_addr = 15'h1234; #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 15'h1234) begin failures++; $display("FAIL read_issue got we=%0h addr=%h exp we=0 addr=1234", mem_we, mem_addr); end
    next_cycle(); disp_re = 1'b0; disp_addr = 15'h0000; #1;
    checks++; if (disp_rdata !== 12'hABC) begin failures++; $display("FAIL read_data got=%h exp=abc", disp_rdata); end
  endtask

  task automatic test_fifo_full();
    clear_log();
    disp_re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = 15'h0200 + 15'(i); wr_data = 12'h100 + 12'(i);
      next_cycle();
    end
    disp_re = 1'b0; wr_valid = 1'b1; wr_addr = 15'h0204; wr_data = 12'h104; #1;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%0h exp=0", wr_ready); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 15'h0200) begin failures++; $display("FAIL full_first_pop got we=%0h addr=%h exp we=1 addr=0200", mem_we, mem_addr); end
    next_cycle(); #1;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL full_next_ready got=%0h exp=1", wr_ready); end
    next_cycle(); wr_valid = 1'b0;
    repeat (5) next_cycle();
    checks++;
    if (log_addr.size() != 5) begin
      failures++; $display("FAIL full_count got=%0d exp=5", log_addr.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (log_addr[i] !== 15'h0200 + 15'(i) || log_data[i] !== 12'h100 + 12'(i)) begin
          failures++;
          $display("FAIL full_order[%0d] got addr=%h data=%h exp addr=%h data=%h",
                   i, log_addr[i], log_data[i], 15'h0200 + 15'(i), 12'h100 + 12'(i));
          break;
        end
      end
    end
  endtask

`ifdef VRAM_CLEAR_EN
  task automatic test_clear();
    int last_cyc = -1;
    int end_cyc  = -1;
    int bad      = 0;
    clear_log();
    disp_re = 1'b1; disp_addr = 15'h0000;
    wr_valid = 1'b1; wr_addr = 15'h0300; wr_data = 12'h5A5; next_cycle();
    wr_addr = 15'h0301; wr_data = 12'hA5A; next_cycle();
    wr_valid = 1'b0; clr_req = 1'b1; clr_color = 12'h3C7; #1;
    checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL clr_busy_same got=%0h exp=0", clr_busy); end
    next_cycle(); clr_req = 1'b0; clr_color = 12'h000; #1;
    checks++; if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin failures++; $display("FAIL clr_busy_next got busy=%0h ready=%0h exp busy=1 ready=0", clr_busy, wr_ready); end
    for (int c = 0; c < 50000; c++) begin
      next_cycle();
      disp_re = (c % 4 == 0);
      clr_req = (c == 500); clr_color = (c == 500) ? 12'hFFF : 12'h000;
      #1;
      if (!clr_busy) begin end_cyc = c; break; end
      if (mem_we && mem_addr == 15'd29999) last_cyc = c;
    end
    clr_req = 1'b0; disp_re = 1'b0;
    checks++; if (end_cyc < 0 || end_cyc != last_cyc + 1) begin failures++; $display("FAIL clr_busy_fall got end=%0d exp=%0d", end_cyc, last_cyc + 1); end
    checks++; if (we_during_re != 0) begin failures++; $display("FAIL clr_we_during_read got=%0d exp=0", we_during_re); end
    checks++;
    if (log_addr.size() != 30002) begin
      failures++; $display("FAIL clr_count got=%0d exp=30002", log_addr.size());
    end else begin
      if (log_addr[0] !== 15'h0300 || log_data[0] !== 12'h5A5 ||
          log_addr[1] !== 15'h0301 || log_data[1] !== 12'hA5A) bad++;
      for (int k = 0; k < 30000; k++)
        if (log_addr[k+2] !== 15'(k) || log_data[k+2] !== 12'h3C7) bad++;
      if (bad != 0) begin failures++; $display("FAIL clr_contents got bad=%0d exp=0", bad); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int hit = 0;
    clear_log();
    disp_re = 1'b0; clr_req = 1'b1; clr_color = 12'h0F0; next_cycle(); clr_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (mem_we && mem_addr == 15'd100) begin hit = 1; break; end
      next_cycle();
    end
    checks++; if (hit != 1) begin failures++; $display("FAIL mid_clear_reach got=%0d exp=1", hit); end
    rst = 1'b1; #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mid_clear_rst_we got=%0h exp=0", mem_we); end
    next_cycle(); rst = 1'b0; clear_log(); #1;
    checks++; if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL mid_clear_release got busy=%0h ready=%0h exp busy=0 ready=1", clr_busy, wr_ready); end
    repeat (20) next_cycle();
    checks++; if (log_addr.size() != 0) begin failures++; $display("FAIL mid_clear_no_writes got=%0d exp=0", log_addr.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_display_priority();
    test_read_path();
    test_fifo_full();
`ifdef VRAM_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
